song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Note store and playback engine sitting directly downstream of the composer controller.
//  Consumes its level enables (InsertEnable/deleteEnable/playEnable) and returns is_full,
//  insert_delay_done and play_done. Holds the user song in a small register file and
//  streams notes (user or preset) to the tone generator and VGA score drawer.
// PARAMETERS
//  MAX_NOTES     16          song capacity in notes; PTR_W = $clog2(MAX_NOTES)
//  NOTE_W        4           note code width; code 0 = rest
//  NOTE_TICKS    12_500_000  clk cycles each note is presented during playback (>=1)
//  DELAY_CYCLES  25_000_000  post-insert debounce delay in clk cycles (>=1)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        synchronous, active-high
//  restart        in   1        pulse: clear user song (count->0), abort any activity
//  insert_en      in   1        level; rising edge = append note_in
//  delete_en      in   1        level; rising edge = remove last note
//  play_en        in   1        level; rising edge = start playback; low = abort
//  song_src       in   2        0 = user song, 1..3 = preset song; sampled at play start
//  note_in        in   NOTE_W   note to append
//  is_full        out  1        count == MAX_NOTES
//  count          out  PTR_W+1  notes stored (0..MAX_NOTES)
//  insert_delay_done out 1      insert complete, held until insert_en low
//  play_done      out  1        playback finished, held until play_en low
//  play_valid     out  1        play_note valid
//  play_note      out  NOTE_W   current note to sound
//  play_index     out  PTR_W    index of current note
//  wr_strobe      out  1        1-cycle pulse: score cell changed
//  wr_erase       out  1        with wr_strobe: 1 = erase cell, 0 = draw wr_note
//  wr_index       out  PTR_W    cell index;  wr_note out NOTE_W  note drawn
// BEHAVIOUR
//  Reset/restart: all outputs 0, count 0, FSM IDLE, counters 0; same cycle effect (sync).
//  Edge detect: registered copy of each *_en; edge = en & ~en_q. Priority when several
//   edges coincide: play > delete > insert. Edges outside IDLE are ignored.
//  FSM:
//   IDLE      insert edge & ~is_full -> mem[count]<=note_in, count++, wr_strobe (draw,
//             wr_index=old count) -> INS_DLY. Insert edge when full: no write -> INS_HOLD.
//             delete edge & count>0 -> count--, wr_strobe+wr_erase at new count -> DEL_HOLD;
//             count==0 -> DEL_HOLD, no strobe.
//             play edge -> latch song_src, length (user: count; preset: ROM length),
//             index 0 -> PLAY; length 0 -> PLAY_HOLD directly.
//   INS_DLY   count DELAY_CYCLES cycles -> INS_HOLD; insert_en low early -> IDLE.
//   INS_HOLD  insert_delay_done=1; insert_en low -> IDLE.
//   DEL_HOLD  delete_en low -> IDLE (one delete per press).
//   PLAY      play_valid=1; note held NOTE_TICKS cycles then index++; after index
//             length-1 expires -> PLAY_HOLD. play_en low -> IDLE, play_valid 0 next cycle.
//   PLAY_HOLD play_done=1, play_valid=0; play_en low -> IDLE (re-edge replays).
//  Latency: play_note of index 0 valid the cycle after the play edge is registered.
//  count saturates at MAX_NOTES / 0; never wraps. Indices width PTR_W, compare full width.
//  restart overrides all states and edges in the same cycle; reset overrides restart.
//  insert_en/delete_en/play_en arriving one cycle late (controller registers enables) is legal.
// STRUCTURE
//  composer_pkg: note codes (NOTE_REST=0, C4..B4), seq FSM state encodings, PRESET_MAX_LEN.
//  Sub-module preset_song_rom: combinational (sel, idx) -> (note, length), 3 fixed songs.
//  Top: edge detectors, FSM, tick/delay counter (shared, max(NOTE_TICKS,DELAY_CYCLES)),
//  MAX_NOTES x NOTE_W register file, output regs.
// TESTING  (MAX_NOTES=4, NOTE_TICKS=3, DELAY_CYCLES=5)
//  1 Insert 5,7,9 (hold insert_en until insert_delay_done) -> count 3, wr_strobe idx 0,1,2,
//    insert_delay_done rises 5 cycles after each write.
//  2 Insert 4 notes then a 5th -> is_full=1 after 4th, 5th: no write, count stays 4,
//    insert_delay_done still asserted.
//  3 Delete held 20 cycles with count 3 -> single decrement to 2, wr_erase at idx 2;
//    delete at count 0 -> no strobe, count 0.
//  4 Play user song {5,7,9} -> play_note 5,7,9 each 3 cycles, play_index 0..2,
//    then play_done=1 until play_en drops; re-raise play_en -> identical replay.
//  5 Play with count 0 -> play_done next state, play_valid never high; play_en dropped
//    mid-note 1 -> play_valid 0 within 1 cycle, FSM IDLE.
//  6 restart during PLAY and during INS_DLY -> count 0, all outputs 0 next cycle;
//    reset asserted with restart -> reset values; song_src=2 plays ROM song 2 verbatim.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// Shared note codes, sequencer state encodings and preset song dimensions.
package song_sequencer_pkg;

    localparam int unsigned NOTE_CODE_W    = 4;
    localparam int unsigned SRC_W          = 2;
    localparam int unsigned PRESET_MAX_LEN = 4;
    localparam int unsigned PRESET_IDX_W   = $clog2(PRESET_MAX_LEN);
    localparam int unsigned PRESET_LEN_W   = $clog2(PRESET_MAX_LEN + 1);

    typedef enum logic [NOTE_CODE_W-1:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_D4   = 4'd2,
        NOTE_E4   = 4'd3,
        NOTE_F4   = 4'd4,
        NOTE_G4   = 4'd5,
        NOTE_A4   = 4'd6,
        NOTE_B4   = 4'd7
    } note_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INS_DLY   = 3'd1,
        ST_INS_HOLD  = 3'd2,
        ST_DEL_HOLD  = 3'd3,
        ST_PLAY      = 3'd4,
        ST_PLAY_HOLD = 3'd5
    } seq_state_e;

endpackage

// File: rtl/preset_song_rom.sv
// Fixed preset songs: (song select, note index) -> (note code, song length).
module preset_song_rom
    import song_sequencer_pkg::*;
(
    input  logic [SRC_W-1:0]        i_sel,
    input  logic [PRESET_IDX_W-1:0] i_idx,
    output logic [NOTE_CODE_W-1:0]  o_note_c,
    output logic [PRESET_LEN_W-1:0] o_len_c
);

    // Select 0 is the user song and has no ROM content; indices past a song's end read as rests.
    always_comb begin
        o_note_c = NOTE_REST;
        o_len_c  = '0;
        case (i_sel)
            2'd1: begin
                o_len_c = PRESET_LEN_W'(4);
                case (i_idx)
                    2'd0:    o_note_c = NOTE_C4;
                    2'd1:    o_note_c = NOTE_E4;
                    2'd2:    o_note_c = NOTE_G4;
                    default: o_note_c = NOTE_E4;
                endcase
            end
            2'd2: begin
                o_len_c = PRESET_LEN_W'(3);
                case (i_idx)
                    2'd0:    o_note_c = NOTE_G4;
                    2'd1:    o_note_c = NOTE_F4;
                    2'd2:    o_note_c = NOTE_E4;
                    default: o_note_c = NOTE_REST;
                endcase
            end
            2'd3: begin
                o_len_c = PRESET_LEN_W'(2);
                case (i_idx)
                    2'd0:    o_note_c = NOTE_A4;
                    2'd1:    o_note_c = NOTE_B4;
                    default: o_note_c = NOTE_REST;
                endcase
            end
            default: begin
                o_note_c = NOTE_REST;
                o_len_c  = '0;
            end
        endcase
    end

endmodule

// File: rtl/song_sequencer.sv
// Note store and playback engine: appends/removes user notes and streams user or preset songs.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter  int unsigned MAX_NOTES    = 16,
    parameter  int unsigned NOTE_W       = 4,
    parameter  int unsigned NOTE_TICKS   = 12_500_000,
    parameter  int unsigned DELAY_CYCLES = 25_000_000,
    localparam int unsigned PTR_W        = $clog2(MAX_NOTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              insert_en,
    input  logic              delete_en,
    input  logic              play_en,
    input  logic [SRC_W-1:0]  song_src,
    input  logic [NOTE_W-1:0] note_in,
    output logic              is_full,
    output logic [PTR_W:0]    count,
    output logic              insert_delay_done,
    output logic              play_done,
    output logic              play_valid,
    output logic [NOTE_W-1:0] play_note,
    output logic [PTR_W-1:0]  play_index,
    output logic              wr_strobe,
    output logic              wr_erase,
    output logic [PTR_W-1:0]  wr_index,
    output logic [NOTE_W-1:0] wr_note
);

    localparam int unsigned CNT_OUT_W = PTR_W + 1;
    localparam int unsigned CNT_MAX   = (NOTE_TICKS > DELAY_CYCLES) ? NOTE_TICKS : DELAY_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0]     DLY_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_OUT_W-1:0] FULL_CNT  = CNT_OUT_W'(MAX_NOTES);

    seq_state_e          r_state;
    logic                r_ins_q;
    logic                r_del_q;
    logic                r_ply_q;
    logic [NOTE_W-1:0]   r_mem [MAX_NOTES];
    logic [PTR_W:0]      r_count;
    logic                r_full;
    logic [SRC_W-1:0]    r_src;
    logic [PTR_W:0]      r_len;
    logic [PTR_W-1:0]    r_index;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_idd;
    logic                r_pd;
    logic                r_pv;
    logic [NOTE_W-1:0]   r_pn;
    logic [PTR_W-1:0]    r_pi;
    logic                r_ws;
    logic                r_we;
    logic [PTR_W-1:0]    r_wi;
    logic [NOTE_W-1:0]   r_wn;

    logic                    w_ins_edge;
    logic                    w_del_edge;
    logic                    w_ply_edge;
    logic                    w_idle;
    logic [SRC_W-1:0]        w_rd_sel;
    logic [PTR_W-1:0]        w_rd_idx;
    logic [PRESET_IDX_W-1:0] w_rom_idx;
    logic [NOTE_CODE_W-1:0]  w_rom_note;
    logic [PRESET_LEN_W-1:0] w_rom_len;
    logic [PTR_W:0]          w_preset_len;
    logic [PTR_W:0]          w_play_len;
    logic [NOTE_W-1:0]       w_rd_note;
    logic                    w_last_note;
    logic [PTR_W:0]          w_count_p1;
    logic [PTR_W:0]          w_count_m1;

    assign w_ins_edge = insert_en & ~r_ins_q;
    assign w_del_edge = delete_en & ~r_del_q;
    assign w_ply_edge = play_en & ~r_ply_q;
    assign w_idle     = (r_state == ST_IDLE);

    // In IDLE the read port looks at note 0 of the song being requested, so the first
    // note can be registered on the same edge that starts playback.
    assign w_rd_sel  = w_idle ? song_src : r_src;
    assign w_rd_idx  = w_idle ? '0 : r_index + PTR_W'(1);
    assign w_rom_idx = PRESET_IDX_W'(w_rd_idx);

    preset_song_rom u_rom (
        .i_sel    (w_rd_sel),
        .i_idx    (w_rom_idx),
        .o_note_c (w_rom_note),
        .o_len_c  (w_rom_len)
    );

    assign w_preset_len = (32'(w_rom_len) > MAX_NOTES) ? FULL_CNT : CNT_OUT_W'(w_rom_len);
    assign w_play_len   = (song_src == '0) ? r_count : w_preset_len;
    assign w_rd_note    = (w_rd_sel == '0) ? r_mem[w_rd_idx] : NOTE_W'(w_rom_note);
    assign w_last_note  = ({1'b0, r_index} == (r_len - CNT_OUT_W'(1)));
    assign w_count_p1   = r_count + CNT_OUT_W'(1);
    assign w_count_m1   = r_count - CNT_OUT_W'(1);

    // Sequencer FSM with registered outputs; restart beats every state, reset beats restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ins_q <= 1'b0;
            r_del_q <= 1'b0;
            r_ply_q <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_src   <= '0;
            r_len   <= '0;
            r_index <= '0;
            r_cnt   <= '0;
            r_idd   <= 1'b0;
            r_pd    <= 1'b0;
            r_pv    <= 1'b0;
            r_pn    <= '0;
            r_pi    <= '0;
            r_ws    <= 1'b0;
            r_we    <= 1'b0;
            r_wi    <= '0;
            r_wn    <= '0;
        end else begin
            r_ins_q <= insert_en;
            r_del_q <= delete_en;
            r_ply_q <= play_en;
            r_ws    <= 1'b0;
            r_we    <= 1'b0;
            r_wi    <= '0;
            r_wn    <= '0;
            if (restart) begin
                r_state <= ST_IDLE;
                r_count <= '0;
                r_full  <= 1'b0;
                r_src   <= '0;
                r_len   <= '0;
                r_index <= '0;
                r_cnt   <= '0;
                r_idd   <= 1'b0;
                r_pd    <= 1'b0;
                r_pv    <= 1'b0;
                r_pn    <= '0;
                r_pi    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ply_edge) begin
                            r_src   <= song_src;
                            r_len   <= w_play_len;
                            r_index <= '0;
                            r_cnt   <= '0;
                            if (w_play_len == '0) begin
                                r_state <= ST_PLAY_HOLD;
                                r_pd    <= 1'b1;
                            end else begin
                                r_state <= ST_PLAY;
                                r_pv    <= 1'b1;
                                r_pn    <= w_rd_note;
                                r_pi    <= '0;
                            end
                        end else if (w_del_edge) begin
                            r_state <= ST_DEL_HOLD;
                            if (r_count != '0) begin
                                r_count <= w_count_m1;
                                r_full  <= 1'b0;
                                r_ws    <= 1'b1;
                                r_we    <= 1'b1;
                                r_wi    <= w_count_m1[PTR_W-1:0];
                            end
                        end else if (w_ins_edge) begin
                            if (r_full) begin
                                r_state <= ST_INS_HOLD;
                                r_idd   <= 1'b1;
                            end else begin
                                r_mem[r_count[PTR_W-1:0]] <= note_in;
                                r_count <= w_count_p1;
                                r_full  <= (w_count_p1 == FULL_CNT);
                                r_ws    <= 1'b1;
                                r_wi    <= r_count[PTR_W-1:0];
                                r_wn    <= note_in;
                                r_cnt   <= '0;
                                r_state <= ST_INS_DLY;
                            end
                        end
                    end
                    ST_INS_DLY: begin
                        if (!insert_en) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == DLY_LAST) begin
                            r_state <= ST_INS_HOLD;
                            r_idd   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_INS_HOLD: begin
                        if (!insert_en) begin
                            r_state <= ST_IDLE;
                            r_idd   <= 1'b0;
                        end
                    end
                    ST_DEL_HOLD: begin
                        if (!delete_en) r_state <= ST_IDLE;
                    end
                    ST_PLAY: begin
                        if (!play_en) begin
                            r_state <= ST_IDLE;
                            r_pv    <= 1'b0;
                            r_pn    <= '0;
                            r_pi    <= '0;
                            r_cnt   <= '0;
                        end else if (r_cnt == TICK_LAST) begin
                            r_cnt <= '0;
                            if (w_last_note) begin
                                r_state <= ST_PLAY_HOLD;
                                r_pv    <= 1'b0;
                                r_pn    <= '0;
                                r_pi    <= '0;
                                r_pd    <= 1'b1;
                            end else begin
                                r_index <= w_rd_idx;
                                r_pi    <= w_rd_idx;
                                r_pn    <= w_rd_note;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_PLAY_HOLD: begin
                        if (!play_en) begin
                            r_state <= ST_IDLE;
                            r_pd    <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign is_full           = r_full;
    assign count             = r_count;
    assign insert_delay_done = r_idd;
    assign play_done         = r_pd;
    assign play_valid        = r_pv;
    assign play_note         = r_pn;
    assign play_index        = r_pi;
    assign wr_strobe         = r_ws;
    assign wr_erase          = r_we;
    assign wr_index          = r_wi;
    assign wr_note           = r_wn;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: per-cycle vector table plus hand-written playback/restart sequences.
module tb_song_sequencer;

    typedef struct packed {
        logic       rst;
        logic       rs;
        logic       ins;
        logic       del;
        logic       ply;
        logic [1:0] src;
        logic [3:0] note;
    } vin_t;

    typedef struct packed {
        logic [2:0] cnt;
        logic       full;
        logic       idd;
        logic       pd;
        logic       pv;
        logic [3:0] pn;
        logic [1:0] pi;
        logic       ws;
        logic       we;
        logic [1:0] wi;
        logic [3:0] wn;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, restart, insert_en, delete_en, play_en;
    logic [1:0] song_src;
    logic [3:0] note_in;
    logic       is_full, insert_delay_done, play_done, play_valid, wr_strobe, wr_erase;
    logic [2:0] count;
    logic [3:0] play_note, wr_note;
    logic [1:0] play_index, wr_index;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs[$];

    song_sequencer #(
        .MAX_NOTES    (4),
        .NOTE_W       (4),
        .NOTE_TICKS   (3),
        .DELAY_CYCLES (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .restart           (restart),
        .insert_en         (insert_en),
        .delete_en         (delete_en),
        .play_en           (play_en),
        .song_src          (song_src),
        .note_in           (note_in),
        .is_full           (is_full),
        .count             (count),
        .insert_delay_done (insert_delay_done),
        .play_done         (play_done),
        .play_valid        (play_valid),
        .play_note         (play_note),
        .play_index        (play_index),
        .wr_strobe         (wr_strobe),
        .wr_erase          (wr_erase),
        .wr_index          (wr_index),
        .wr_note           (wr_note)
    );

    always #5 clk = ~clk;

    function automatic vin_t mk_in(input logic rst, input logic rs, input logic ins,
                                   input logic del, input logic ply, input logic [1:0] src,
                                   input logic [3:0] note);
        vin_t v;
        v.rst = rst; v.rs = rs; v.ins = ins; v.del = del; v.ply = ply; v.src = src; v.note = note;
        return v;
    endfunction

    function automatic vin_t i_lv(input logic ins, input logic del, input logic [3:0] note);
        return mk_in(1'b0, 1'b0, ins, del, 1'b0, 2'd0, note);
    endfunction

    function automatic vout_t o_all(input logic [2:0] cnt, input logic full, input logic idd,
                                    input logic pd, input logic pv, input logic [3:0] pn,
                                    input logic [1:0] pi, input logic ws, input logic we,
                                    input logic [1:0] wi, input logic [3:0] wn);
        vout_t o;
        o.cnt = cnt; o.full = full; o.idd = idd; o.pd = pd; o.pv = pv; o.pn = pn; o.pi = pi;
        o.ws = ws; o.we = we; o.wi = wi; o.wn = wn;
        return o;
    endfunction

    function automatic vout_t o_st(input logic [2:0] cnt, input logic full, input logic idd);
        return o_all(cnt, full, idd, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    endfunction

    function automatic vout_t o_wr(input logic [2:0] cnt, input logic full, input logic we,
                                   input logic [1:0] wi, input logic [3:0] wn);
        return o_all(cnt, full, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1, we, wi, wn);
    endfunction

    function automatic vout_t o_pl(input logic [2:0] cnt, input logic pd, input logic pv,
                                   input logic [3:0] pn, input logic [1:0] pi);
        return o_all(cnt, 1'b0, 1'b0, pd, pv, pn, pi, 1'b0, 1'b0, 2'd0, 4'd0);
    endfunction

    function automatic vout_t sample();
        return o_all(count, is_full, insert_delay_done, play_done, play_valid, play_note,
                     play_index, wr_strobe, wr_erase, wr_index, wr_note);
    endfunction

    task automatic drive(input vin_t v);
        reset     = v.rst;
        restart   = v.rs;
        insert_en = v.ins;
        delete_en = v.del;
        play_en   = v.ply;
        song_src  = v.src;
        note_in   = v.note;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input vout_t act, input vout_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h (cnt,full,idd,pd,pv,pn,pi,ws,we,wi,wn)", nm, act, exp);
        end
    endtask

    task automatic push(input vin_t i, input vout_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    // One complete insert press: write, 5-cycle delay, done, release.
    task automatic ins_seq(input logic [3:0] n, input logic [1:0] idx);
        logic [2:0] c;
        logic       f;
        c = 3'(idx) + 3'd1;
        f = (c == 3'd4);
        push(i_lv(1'b1, 1'b0, n), o_wr(c, f, 1'b0, idx, n));
        for (int k = 0; k < 4; k++) push(i_lv(1'b1, 1'b0, n), o_st(c, f, 1'b0));
        push(i_lv(1'b1, 1'b0, n), o_st(c, f, 1'b1));
        push(i_lv(1'b0, 1'b0, 4'd0), o_st(c, f, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] usr [3];
        logic [3:0] rom2 [3];
        vout_t      zero;
        usr[0] = 4'd5; usr[1] = 4'd7; usr[2] = 4'd9;
        rom2[0] = 4'd5; rom2[1] = 4'd4; rom2[2] = 4'd3;
        zero = '0;

        drive(mk_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));

        push(mk_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0), zero);
        push(i_lv(1'b0, 1'b0, 4'd0), zero);
        ins_seq(4'd5, 2'd0);
        ins_seq(4'd7, 2'd1);
        ins_seq(4'd9, 2'd2);
        ins_seq(4'd2, 2'd3);
        // Fifth insert while full: no write, done still reported.
        for (int k = 0; k < 3; k++) push(i_lv(1'b1, 1'b0, 4'd6), o_st(3'd4, 1'b1, 1'b1));
        push(i_lv(1'b0, 1'b0, 4'd0), o_st(3'd4, 1'b1, 1'b0));
        push(i_lv(1'b0, 1'b1, 4'd0), o_wr(3'd3, 1'b0, 1'b1, 2'd3, 4'd0));
        push(i_lv(1'b0, 1'b1, 4'd0), o_st(3'd3, 1'b0, 1'b0));
        push(i_lv(1'b0, 1'b0, 4'd0), o_st(3'd3, 1'b0, 1'b0));
        // Delete held 20 cycles from count 3: exactly one decrement.
        push(i_lv(1'b0, 1'b1, 4'd0), o_wr(3'd2, 1'b0, 1'b1, 2'd2, 4'd0));
        for (int k = 0; k < 19; k++) push(i_lv(1'b0, 1'b1, 4'd0), o_st(3'd2, 1'b0, 1'b0));
        push(i_lv(1'b0, 1'b0, 4'd0), o_st(3'd2, 1'b0, 1'b0));
        ins_seq(4'd9, 2'd2);
        // Delete and insert edges together: delete wins, held insert gives no late edge.
        push(i_lv(1'b1, 1'b1, 4'd4), o_wr(3'd2, 1'b0, 1'b1, 2'd2, 4'd0));
        push(i_lv(1'b1, 1'b1, 4'd4), o_st(3'd2, 1'b0, 1'b0));
        push(i_lv(1'b1, 1'b1, 4'd4), o_st(3'd2, 1'b0, 1'b0));
        push(i_lv(1'b1, 1'b0, 4'd4), o_st(3'd2, 1'b0, 1'b0));
        push(i_lv(1'b1, 1'b0, 4'd4), o_st(3'd2, 1'b0, 1'b0));
        push(i_lv(1'b0, 1'b0, 4'd0), o_st(3'd2, 1'b0, 1'b0));
        ins_seq(4'd9, 2'd2);

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            step();
            cmp($sformatf("vec%0d", k), sample(), vecs[k].o);
        end

        // User song {5,7,9}, played twice.
        for (int rep = 0; rep < 2; rep++) begin
            drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0));
            for (int k = 0; k < 9; k++) begin
                step();
                cmp($sformatf("play_user%0d_c%0d", rep, k), sample(),
                    o_pl(3'd3, 1'b0, 1'b1, usr[k/3], 2'(k/3)));
            end
            for (int k = 0; k < 3; k++) begin
                step();
                cmp($sformatf("play_user%0d_done%0d", rep, k), sample(),
                    o_pl(3'd3, 1'b1, 1'b0, 4'd0, 2'd0));
            end
            drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
            step();
            cmp($sformatf("play_user%0d_rel", rep), sample(), o_st(3'd3, 1'b0, 1'b0));
        end

        // Restart during playback; held play_en must not replay afterwards.
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0));
        for (int k = 0; k < 4; k++) step();
        cmp("restart_play_pre", sample(), o_pl(3'd3, 1'b0, 1'b1, 4'd7, 2'd1));
        drive(mk_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0));
        step();
        cmp("restart_play", sample(), zero);
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0));
        for (int k = 0; k < 3; k++) begin
            step();
            cmp($sformatf("restart_play_after%0d", k), sample(), zero);
        end
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        step();

        // Delete on an empty song.
        drive(i_lv(1'b0, 1'b1, 4'd0));
        step();
        cmp("del_empty", sample(), zero);
        step();
        drive(i_lv(1'b0, 1'b0, 4'd0));
        step();
        cmp("del_empty_rel", sample(), zero);

        // Play with count 0: straight to done, never valid.
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0));
        for (int k = 0; k < 4; k++) begin
            step();
            cmp($sformatf("play_empty%0d", k), sample(), o_pl(3'd0, 1'b1, 1'b0, 4'd0, 2'd0));
        end
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        step();
        cmp("play_empty_rel", sample(), zero);

        // Restart inside the insert delay.
        drive(i_lv(1'b1, 1'b0, 4'd3));
        step();
        cmp("ins_dly_write", sample(), o_wr(3'd1, 1'b0, 1'b0, 2'd0, 4'd3));
        step();
        step();
        cmp("ins_dly_wait", sample(), o_st(3'd1, 1'b0, 1'b0));
        drive(mk_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3));
        step();
        cmp("restart_ins", sample(), zero);
        drive(i_lv(1'b1, 1'b0, 4'd3));
        for (int k = 0; k < 6; k++) begin
            step();
            cmp($sformatf("restart_ins_after%0d", k), sample(), zero);
        end
        drive(i_lv(1'b0, 1'b0, 4'd0));
        step();

        // Preset song 2 played verbatim.
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        for (int k = 0; k < 9; k++) begin
            step();
            cmp($sformatf("play_rom2_c%0d", k), sample(), o_pl(3'd0, 1'b0, 1'b1, rom2[k/3], 2'(k/3)));
        end
        step();
        cmp("play_rom2_done", sample(), o_pl(3'd0, 1'b1, 1'b0, 4'd0, 2'd0));
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
        step();
        cmp("play_rom2_rel", sample(), zero);

        // Abort during note 1.
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        for (int k = 0; k < 4; k++) begin
            step();
            cmp($sformatf("abort_c%0d", k), sample(), o_pl(3'd0, 1'b0, 1'b1, rom2[k/3], 2'(k/3)));
        end
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
        step();
        cmp("abort_drop", sample(), zero);
        step();
        cmp("abort_idle", sample(), zero);

        // Reset with restart clears the enable history, so a held play_en starts again.
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        step();
        drive(mk_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        step();
        cmp("reset_restart", sample(), zero);
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0));
        step();
        cmp("reset_replay", sample(), o_pl(3'd0, 1'b0, 1'b1, 4'd5, 2'd0));
        drive(mk_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));
        step();
        cmp("reset_replay_drop", sample(), zero);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
